// File: rtl/cloud_render.sv
// Background cloud renderer: descriptors are snapshotted once per frame, then a
// 2-stage pipeline (box test + sprite address, sprite ROM read) flags cloud pixels.
module cloud_render #(
    parameter int CLOUD_W  = 48,
    parameter int CLOUD_H  = 16,
    parameter int BASE_ROW = 40,
    parameter int ROW_STEP = 2,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic [15:0] cloud1,
    input  logic [15:0] cloud2,
    input  logic [15:0] cloud3,
    input  logic [15:0] cloud4,
    output logic        cloud_pix,
    output logic        cloud_box
);
    localparam int ROM_BITS = CLOUD_W * CLOUD_H;
    localparam int AW       = $clog2(ROM_BITS);

    // Outline half-width per row of the 48x16 reference sprite; the increments
    // never grow going down, which keeps the silhouette convex.
    function automatic int profile(input int idx);
        case (idx)
            0:       return 6;
            1:       return 9;
            2:       return 12;
            3:       return 14;
            4:       return 16;
            5:       return 18;
            6:       return 19;
            7:       return 20;
            8:       return 21;
            9:       return 22;
            10:      return 23;
            default: return 24;
        endcase
    endfunction

    function automatic logic [ROM_BITS-1:0] build_rom();
        logic [ROM_BITS-1:0] r;
        int half;
        int w;
        r    = '0;
        half = CLOUD_W / 2;
        for (int y = 0; y < CLOUD_H; y++) begin
            w = (profile((y * 16) / CLOUD_H) * CLOUD_W) / 48;
            for (int x = 0; x < CLOUD_W; x++) begin
                if (x >= half - w && x < half + w) r[y*CLOUD_W + x] = 1'b1;
            end
        end
        return r;
    endfunction

    localparam logic [ROM_BITS-1:0] ROM = build_rom();

    logic [15:0]   cloud_in [4];
    logic [15:0]   snap     [4];
    logic [9:0]    top      [4];
    logic [11:0]   dx       [4];
    logic [9:0]    dy       [4];
    logic [3:0]    hit_d;
    logic [AW-1:0] addr_d   [4];
    logic [3:0]    hit_q;
    logic [AW-1:0] addr_q   [4];
    logic [3:0]    pix_d;

    always_comb begin
        cloud_in[0] = cloud1;
        cloud_in[1] = cloud2;
        cloud_in[2] = cloud3;
        cloud_in[3] = cloud4;
    end

    // Frame snapshot: taken only on the first blanking line so no cloud tears.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                snap[i] <= '0;
            end else if (row_addr == 9'(V_ACTIVE) && col_addr == 10'd0) begin
                snap[i] <= cloud_in[i];
            end
        end
    end

    // Stage 1 geometry: col is the right-exclusive edge, so dx is biased by CLOUD_W.
    always_comb begin
        hit_d = '0;
        for (int i = 0; i < 4; i++) begin
            top[i]    = 10'(BASE_ROW) + 10'(ROW_STEP) * {5'b0, snap[i][14:10]};
            dx[i]     = {2'b0, col_addr} + 12'(CLOUD_W) - {2'b0, snap[i][9:0]};
            dy[i]     = {1'b0, row_addr} - top[i];
            hit_d[i]  = snap[i][15] && !dx[i][11] && (dx[i] < 12'(CLOUD_W))
                        && !dy[i][9] && (dy[i] < 10'(CLOUD_H));
            addr_d[i] = hit_d[i] ? AW'(32'(dy[i]) * CLOUD_W + 32'(dx[i])) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= '0;
            for (int i = 0; i < 4; i++) addr_q[i] <= '0;
        end else begin
            hit_q <= hit_d;
            for (int i = 0; i < 4; i++) addr_q[i] <= addr_d[i];
        end
    end

    always_comb begin
        pix_d = '0;
        for (int i = 0; i < 4; i++) pix_d[i] = hit_q[i] & ROM[addr_q[i]];
    end

    // Stage 2: overlapping clouds simply OR together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cloud_pix <= 1'b0;
            cloud_box <= 1'b0;
        end else begin
            cloud_pix <= |pix_d;
            cloud_box <= |hit_q;
        end
    end

endmodule
